input_capture: RTL and testbench
================================

Name: input_capture

Overview:
- Input side of the shared data bus. The display unit is the output side.
- Synchronizes and debounces the active-low execute pushbutton, and latches the 10 data switches on each clean press.
- Presents the captured word to the controller with a VALID/ACK handshake.
- The controller drives DATA onto BUS during its external-load timestep and pulses ACK.

Parameters:
- DATA_W, 10, width of the switch word and of DATA (matches BUS).
- DB_CYCLES, 500000, consecutive cycles the synchronized button must differ from its stable level before the stable level flips (10 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop stages in the synchronizer on EXECb and on SW; minimum 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SW  in  DATA_W  raw data switches (asynchronous).
- EXECb  in  1  raw execute pushbutton, active-low, bouncy.
- ACK  in  1  controller has consumed DATA; single-cycle or level, sampled each cycle.
- DATA  out  DATA_W  captured switch word, to the bus driver.
- VALID  out  1  DATA holds an unconsumed word.
- PRESSED  out  1  debounced button level, 1 = held.
- OVR  out  1  sticky overrun: a press arrived while VALID was 1.

Behaviour:
- Reset (RST high at a clock edge):
  - DATA=0, VALID=0, OVR=0, PRESSED=0.
  - Synchronizer flops are set to 1 (button released); switch synchronizer flops are cleared.
  - Debounce counter is cleared; FSM goes to IDLE.
  - Reset mid-handshake discards the pending word.
  - A button held through reset produces exactly one new capture, DB_CYCLES after the synchronizer settles.
- Synchronizer: EXECb and SW each pass through SYNC_STAGES flops. Only the synchronized copies are used downstream.
- Debounce:
  - Stable level starts at 1 (released).
  - The counter increments on each cycle where the synchronized level differs from the stable level, and clears on any cycle where they match.
  - When the counter equals DB_CYCLES-1 and the levels still differ, the stable level flips and the counter clears on that edge.
  - Glitches shorter than DB_CYCLES cycles never change the stable level.
  - PRESSED = NOT stable.
- Press event: a one-cycle pulse when stable goes 1->0. Release event: when stable goes 0->1.
- FSM, states IDLE, PRESENT, WAIT_REL:
  - IDLE, press event: DATA <= synchronized SW; VALID <= 1; go to PRESENT.
  - PRESENT, ACK=1: VALID <= 0. Go to WAIT_REL if PRESSED=1, else IDLE. DATA keeps its value.
  - PRESENT, press event: OVR <= 1. DATA is not overwritten.
  - PRESENT, press event and ACK in the same cycle: apply both rules (OVR set, handshake completes).
  - WAIT_REL, release event: go to IDLE. No capture happens until the button is released and pressed again.
  - ACK while VALID=0 is ignored.
  - OVR clears only on RST.
- Latency:
  - VALID rises SYNC_STAGES+DB_CYCLES+1 clock edges after EXECb is first sampled low, provided it stays low.
  - VALID falls on the edge after ACK is sampled high.
- Width: DATA is exactly DATA_W bits; no extension or truncation. SW is captured as one synchronized snapshot on the press cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package proj2_pkg holds:
  - the enum cap_state_t {IDLE, PRESENT, WAIT_REL};
  - the constant DATA_W=10, shared with the display and register file.
- One sub-module, debounce: holds the synchronizer, stable level and counter for a single bit. It outputs stable, press_pulse and release_pulse, and takes DB_CYCLES and SYNC_STAGES as parameters.
- Switch synchronization and the FSM live in input_capture.

Test Plan (DB_CYCLES=4, SYNC_STAGES=2):
- Reset: RST high 2 cycles, inputs random -> DATA=0, VALID=0, OVR=0, PRESSED=0.
- Clean press: SW=10'h2A5, EXECb low and held -> VALID=1 and DATA=10'h2A5 exactly 7 edges after the first low sample. ACK pulsed 1 cycle -> VALID=0 on the next edge, DATA stays 10'h2A5, state WAIT_REL.
- Bounce rejection: EXECb low 3 cycles, high 1, low 2, then high -> PRESSED never 1, VALID stays 0.
- Single capture per press: hold EXECb low 50 cycles, ACK, change SW to 10'h001 -> no second VALID. Release, press again -> DATA=10'h001.
- Overrun: first press captures 10'h3FF, no ACK, release, press again with SW=10'h000 -> OVR=1, DATA stays 10'h3FF. ACK -> VALID=0, OVR stays 1 until RST.
- Reset mid-handshake: VALID=1, assert RST while the button is held -> all outputs 0. After release of RST, with the button still held -> exactly one new VALID, 7 edges later.

Source files
------------

// File: rtl/proj2_pkg.sv
// Definitions shared by the input capture, display and register file blocks.
// The bus word width lives here so every block agrees on it.
package proj2_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_REL
    } cap_state_t;

endpackage

// File: rtl/input_capture_debounce.sv
// Single-bit synchronizer plus debouncer for an active-low button.
// Emits the stable level and one-cycle pulses on each stable transition.
module debounce #(
    parameter int DB_CYCLES   = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stableLevel_q, stableLevel_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   pressPulse_q, pressPulse_d;
    logic                   releasePulse_q, releasePulse_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchronizer resets to 1 so a released button looks idle straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q         <= '1;
            stableLevel_q  <= 1'b1;
            count_q        <= '0;
            pressPulse_q   <= 1'b0;
            releasePulse_q <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], raw_i};
            stableLevel_q  <= stableLevel_d;
            count_q        <= count_d;
            pressPulse_q   <= pressPulse_d;
            releasePulse_q <= releasePulse_d;
        end
    end

    // Pulses are registered alongside the level flip so they line up with the new level.
    always_comb begin
        stableLevel_d  = stableLevel_q;
        count_d        = '0;
        pressPulse_d   = 1'b0;
        releasePulse_d = 1'b0;
        if (synced != stableLevel_q) begin
            if (count_q == LAST_COUNT) begin
                stableLevel_d  = synced;
                pressPulse_d   = ~synced;
                releasePulse_d = synced;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    assign stable_o        = stableLevel_q;
    assign press_pulse_o   = pressPulse_q;
    assign release_pulse_o = releasePulse_q;

endmodule

// File: rtl/input_capture.sv
// Bus input side: debounces the execute button, snapshots the switches on each
// clean press and offers the word to the controller through VALID/ACK.
module input_capture #(
    parameter int DATA_W      = proj2_pkg::DATA_W,
    parameter int DB_CYCLES   = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] SW,
    input  logic              EXECb,
    input  logic              ACK,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    output logic              PRESSED,
    output logic              OVR
);

    import proj2_pkg::*;

    logic [DATA_W-1:0] swSync_q [SYNC_STAGES];
    logic              stableLevel;
    logic              pressEvent;
    logic              releaseEvent;

    cap_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_debounce (
        .clk_i          (CLK),
        .rst_i          (RST),
        .raw_i          (EXECb),
        .stable_o       (stableLevel),
        .press_pulse_o  (pressEvent),
        .release_pulse_o(releaseEvent)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) swSync_q[i] <= '0;
        end else begin
            swSync_q[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) swSync_q[i] <= swSync_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A press while a word is still pending only flags overrun; the pending word is kept.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (pressEvent) begin
                    data_d  = swSync_q[SYNC_STAGES-1];
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (pressEvent) ovr_d = 1'b1;
                if (ACK) begin
                    valid_d = 1'b0;
                    state_d = stableLevel ? IDLE : WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (releaseEvent) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign PRESSED = ~stableLevel;
    assign OVR     = ovr_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with a short debounce window (4 cycles, 2 sync stages).
module tb_input_capture;

    import proj2_pkg::*;

    logic       CLK;
    logic       RST;
    logic [9:0] SW;
    logic       EXECb;
    logic       ACK;
    logic [9:0] DATA;
    logic       VALID;
    logic       PRESSED;
    logic       OVR;

    int checks;
    int failures;

    input_capture #(
        .DATA_W     (10),
        .DB_CYCLES  (4),
        .SYNC_STAGES(2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SW     (SW),
        .EXECb  (EXECb),
        .ACK    (ACK),
        .DATA   (DATA),
        .VALID  (VALID),
        .PRESSED(PRESSED),
        .OVR    (OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle just past the last one before sampling or driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        SW    = 10'($urandom);
        EXECb = 1'($urandom);
        ACK   = 1'($urandom);
        tick(2);
        checks++; if (DATA !== 10'h000) begin failures++; $display("[TB] FAIL reset_data got=%h want=%h", DATA, 10'h000); end
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", VALID); end
        checks++; if (OVR !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovr got=%b want=0", OVR); end
        checks++; if (PRESSED !== 1'b0) begin failures++; $display("[TB] FAIL reset_pressed got=%b want=0", PRESSED); end
        RST   = 1'b0;
        EXECb = 1'b1;
        ACK   = 1'b0;
        SW    = 10'h000;
        tick(3);
    endtask

    task automatic test_clean_press();
        SW    = 10'h2A5;
        EXECb = 1'b0;
        tick(6);
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL press_early_valid got=%b want=0", VALID); end
        tick(1);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL press_valid got=%b want=1", VALID); end
        checks++; if (DATA !== 10'h2A5) begin failures++; $display("[TB] FAIL press_data got=%h want=%h", DATA, 10'h2A5); end
        checks++; if (PRESSED !== 1'b1) begin failures++; $display("[TB] FAIL press_pressed got=%b want=1", PRESSED); end
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL ack_valid got=%b want=0", VALID); end
        checks++; if (DATA !== 10'h2A5) begin failures++; $display("[TB] FAIL ack_data got=%h want=%h", DATA, 10'h2A5); end
        checks++; if (dut.state_q !== WAIT_REL) begin failures++; $display("[TB] FAIL ack_state got=%0d want=%0d", dut.state_q, WAIT_REL); end
        EXECb = 1'b1;
        tick(10);
        checks++; if (PRESSED !== 1'b0) begin failures++; $display("[TB] FAIL release_pressed got=%b want=0", PRESSED); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL release_state got=%0d want=%0d", dut.state_q, IDLE); end
    endtask

    task automatic test_bounce();
        bit sawPressed;
        bit sawValid;
        logic pattern [7];
        pattern = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sawPressed = 1'b0;
        sawValid   = 1'b0;
        SW = 10'h155;
        for (int i = 0; i < 7; i++) begin
            EXECb = pattern[i];
            tick(1);
            if (PRESSED) sawPressed = 1'b1;
            if (VALID) sawValid = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (PRESSED) sawPressed = 1'b1;
            if (VALID) sawValid = 1'b1;
        end
        checks++; if (sawPressed !== 1'b0) begin failures++; $display("[TB] FAIL bounce_pressed got=%b want=0", sawPressed); end
        checks++; if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL bounce_valid got=%b want=0", sawValid); end
    endtask

    task automatic test_single_capture();
        bit sawValid;
        SW    = 10'h3C3;
        EXECb = 1'b0;
        tick(7);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid got=%b want=1", VALID); end
        checks++; if (DATA !== 10'h3C3) begin failures++; $display("[TB] FAIL hold_data got=%h want=%h", DATA, 10'h3C3); end
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        SW  = 10'h001;
        sawValid = 1'b0;
        for (int i = 0; i < 42; i++) begin
            tick(1);
            if (VALID) sawValid = 1'b1;
        end
        checks++; if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL hold_second_valid got=%b want=0", sawValid); end
        checks++; if (DATA !== 10'h3C3) begin failures++; $display("[TB] FAIL hold_data_kept got=%h want=%h", DATA, 10'h3C3); end
        EXECb = 1'b1;
        tick(10);
        EXECb = 1'b0;
        tick(7);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL repress_valid got=%b want=1", VALID); end
        checks++; if (DATA !== 10'h001) begin failures++; $display("[TB] FAIL repress_data got=%h want=%h", DATA, 10'h001); end
        ACK = 1'b1;
        tick(1);
        ACK   = 1'b0;
        EXECb = 1'b1;
        tick(10);
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL repress_ack_valid got=%b want=0", VALID); end
    endtask

    task automatic test_overrun();
        SW    = 10'h3FF;
        EXECb = 1'b0;
        tick(7);
        checks++; if (DATA !== 10'h3FF) begin failures++; $display("[TB] FAIL ovr_first_data got=%h want=%h", DATA, 10'h3FF); end
        checks++; if (OVR !== 1'b0) begin failures++; $display("[TB] FAIL ovr_first_flag got=%b want=0", OVR); end
        EXECb = 1'b1;
        tick(10);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL ovr_pending_valid got=%b want=1", VALID); end
        SW    = 10'h000;
        EXECb = 1'b0;
        tick(7);
        checks++; if (OVR !== 1'b1) begin failures++; $display("[TB] FAIL ovr_flag got=%b want=1", OVR); end
        checks++; if (DATA !== 10'h3FF) begin failures++; $display("[TB] FAIL ovr_data_kept got=%h want=%h", DATA, 10'h3FF); end
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL ovr_valid got=%b want=1", VALID); end
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL ovr_ack_valid got=%b want=0", VALID); end
        EXECb = 1'b1;
        tick(10);
        checks++; if (OVR !== 1'b1) begin failures++; $display("[TB] FAIL ovr_sticky got=%b want=1", OVR); end
        ACK = 1'b1;
        tick(2);
        ACK = 1'b0;
        checks++; if (VALID !== 1'b0 || OVR !== 1'b1) begin failures++; $display("[TB] FAIL idle_ack got=%b%b want=01", VALID, OVR); end
    endtask

    task automatic test_reset_mid_handshake();
        SW    = 10'h155;
        EXECb = 1'b0;
        tick(7);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid got=%b want=1", VALID); end
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        checks++; if ({DATA, VALID, PRESSED, OVR} !== 13'h0) begin failures++; $display("[TB] FAIL mid_reset_outputs got=%h/%b%b%b want=000/000", DATA, VALID, PRESSED, OVR); end
        tick(6);
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL mid_early_valid got=%b want=0", VALID); end
        tick(1);
        checks++; if (VALID !== 1'b1) begin failures++; $display("[TB] FAIL mid_new_valid got=%b want=1", VALID); end
        checks++; if (DATA !== 10'h155) begin failures++; $display("[TB] FAIL mid_new_data got=%h want=%h", DATA, 10'h155); end
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        tick(20);
        checks++; if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL mid_single_capture got=%b want=0", VALID); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        SW       = 10'h000;
        EXECb    = 1'b1;
        ACK      = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_single_capture();
        test_overrun();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
